// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA arbiter: CPU-side bus, external memory bus and
// the OAM write port. The arbiter takes the slave view; the environment that
// drives the CPU and the memory takes the master view.
interface oam_dma_if;
    logic        mcyc;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dout;
    logic        cpu_p_rd;
    logic        cpu_p_wr;
    logic [7:0]  cpu_din;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        p_rd;
    logic        n_rd;
    logic        p_wr;
    logic        n_wr;
    logic [7:0]  oam_adr;
    logic [7:0]  oam_wdata;
    logic        oam_we;
    logic        dma_active;

    modport slave (
        input  mcyc, cpu_adr, cpu_dout, cpu_p_rd, cpu_p_wr, din,
        output cpu_din, adr, dout, p_rd, n_rd, p_wr, n_wr,
               oam_adr, oam_wdata, oam_we, dma_active
    );

    modport master (
        output mcyc, cpu_adr, cpu_dout, cpu_p_rd, cpu_p_wr, din,
        input  cpu_din, adr, dout, p_rd, n_rd, p_wr, n_wr,
               oam_adr, oam_wdata, oam_we, dma_active
    );
endinterface

// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: owns the $FF46 register and, after a write to it, copies
// DMA_LEN bytes from {src,00} into OAM, one byte per M-cycle, while holding
// the external bus away from the CPU (only FF00-FFFF stays reachable).
// Optional macro OAM_DMA_BUS_CONFLICT_EN: blocked CPU reads return the byte
// the DMA is fetching instead of FFh.
module oam_dma_arbiter #(
    parameter int DMA_LEN     = 160,
    parameter int START_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    oam_dma_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    localparam logic [7:0]  LAST_IDX   = 8'(DMA_LEN - 1);
    localparam logic [7:0]  DELAY_INIT = 8'(START_DELAY);
    localparam logic [15:0] DMA_REG    = 16'hFF46;

    state_t     state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] count_q, count_d;
    logic [7:0] delay_q, delay_d;
    logic       oam_we_q, oam_we_d;
    logic [7:0] oam_adr_q, oam_adr_d;
    logic [7:0] oam_wdata_q, oam_wdata_d;

    logic       reg_wr;
    logic       cpu_hi;
    logic       cpu_hi_access;
    logic       dma_owns_bus;
    logic [7:0] eff_src;

    assign reg_wr        = bus.mcyc && bus.cpu_p_wr && (bus.cpu_adr == DMA_REG);
    assign cpu_hi        = (bus.cpu_adr[15:8] == 8'hFF);
    assign cpu_hi_access = cpu_hi && (bus.cpu_p_rd || bus.cpu_p_wr);
    assign dma_owns_bus  = (state_q == XFER) && !cpu_hi_access;
    // Sources E0-FF alias down onto C0-DF (echo RAM); the register keeps the raw value.
    assign eff_src       = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

    // State and datapath registers; all next values come from the block below.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= 8'h00;
            count_q     <= 8'h00;
            delay_q     <= 8'h00;
            oam_we_q    <= 1'b0;
            oam_adr_q   <= 8'h00;
            oam_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            count_q     <= count_d;
            delay_q     <= delay_d;
            oam_we_q    <= oam_we_d;
            oam_adr_q   <= oam_adr_d;
            oam_wdata_q <= oam_wdata_d;
        end
    end

    // Next-state logic: register write restarts from anywhere, otherwise advance on mcyc.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        src_d       = src_q;
        count_d     = count_q;
        delay_d     = delay_q;
        oam_we_d    = 1'b0;
        oam_adr_d   = oam_adr_q;
        oam_wdata_d = oam_wdata_q;

        if (reg_wr) begin
            // The bus carries the CPU write this M-cycle, so no byte is copied.
            src_d   = bus.cpu_dout;
            delay_d = DELAY_INIT;
            count_d = 8'h00;
            state_d = START;
        end else if (bus.mcyc) begin
            unique case (state_q)
                START: begin
                    // A delay of zero still spends one M-cycle in START.
                    if (delay_q <= 8'd1) begin
                        delay_d = 8'h00;
                        count_d = 8'h00;
                        state_d = XFER;
                    end else begin
                        delay_d = delay_q - 8'd1;
                    end
                end
                XFER: begin
                    oam_we_d    = 1'b1;
                    oam_adr_d   = count_q;
                    oam_wdata_d = bus.din;
                    if (count_q == LAST_IDX) begin
                        count_d = 8'h00;
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // External bus mux and CPU read-data return.
    always_comb begin
        if (dma_owns_bus) begin
            bus.adr  = {eff_src, count_q};
            bus.dout = 8'h00;
            bus.p_rd = 1'b1;
            bus.p_wr = 1'b0;
        end else begin
            bus.adr  = bus.cpu_adr;
            bus.dout = bus.cpu_dout;
            bus.p_rd = bus.cpu_p_rd;
            bus.p_wr = bus.cpu_p_wr;
        end

        if ((state_q == XFER) && !cpu_hi) begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
            bus.cpu_din = bus.din;
`else
            bus.cpu_din = 8'hFF;
`endif
        end else if (bus.cpu_adr == DMA_REG) begin
            bus.cpu_din = src_q;
        end else begin
            bus.cpu_din = bus.din;
        end
    end

    assign bus.n_rd       = ~bus.p_rd;
    assign bus.n_wr       = ~bus.p_wr;
    assign bus.oam_we     = oam_we_q;
    assign bus.oam_adr    = oam_adr_q;
    assign bus.oam_wdata  = oam_wdata_q;
    assign bus.dma_active = (state_q == XFER);
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: random memory image, a scoreboard of expected OAM
// writes (M-cycle index, index, data) built from the transfer rules, and a
// monitor that pops one entry per oam_we pulse. Bus-level behaviour is probed
// mid M-cycle.
module tb_oam_dma_arbiter;
    localparam int DMA_LEN     = 160;
    localparam int START_DELAY = 1;

    typedef struct {
        int         mc;
        logic [7:0] idx;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]  cdin;
        logic [15:0] adr;
        logic [7:0]  dout;
        logic        p_rd;
        logic        n_rd;
        logic        p_wr;
        logic        n_wr;
    } snap_t;

    logic clk;
    logic reset;
    logic [7:0] mem [0:65535];
    exp_t sb_q[$];
    int errors;
    int checks;
    int mcyc_cnt;
    int done_cnt;
    logic [7:0] cur_eff;

    oam_dma_if bus();

    oam_dma_arbiter #(.DMA_LEN(DMA_LEN), .START_DELAY(START_DELAY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.din = mem[bus.adr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (required finish before 2ms)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // mcyc strobe: one clk in four, index counted as it is raised.
    initial begin
        int phase;
        phase    = 0;
        bus.mcyc = 1'b0;
        mcyc_cnt = 0;
        forever begin
            @(negedge clk);
            phase    = (phase + 1) % 4;
            bus.mcyc = (phase == 0);
            if (phase == 0) mcyc_cnt++;
        end
    end

    // Monitor: every oam_we pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        done_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.oam_we === 1'b1) begin
                done_cnt++;
                check("oam_we_expected", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("oam_mcyc", mcyc_cnt, e.mc);
                    check("oam_adr", bus.oam_adr, e.idx);
                    check("oam_wdata", bus.oam_wdata, e.data);
                    if (e.idx == 8'(DMA_LEN - 1)) check("dma_active_after_last", bus.dma_active, 0);
                end
            end
        end
    end

    task automatic wait_mcyc_high();
        do begin
            @(negedge clk);
            #1;
        end while (bus.mcyc !== 1'b1);
    endtask

    // Write FF46 on an mcyc pulse and load the scoreboard with the whole transfer.
    task automatic reg_write(input logic [7:0] val);
        logic [7:0] eff;
        int p;
        wait_mcyc_high();
        p = mcyc_cnt;
        bus.cpu_adr  = 16'hFF46;
        bus.cpu_dout = val;
        bus.cpu_p_rd = 1'b0;
        bus.cpu_p_wr = 1'b1;
        #1;
        check("wr_fwd_adr", bus.adr, 16'hFF46);
        check("wr_fwd_p_wr", bus.p_wr, 1);
        check("wr_fwd_dout", bus.dout, val);
        eff = (val >= 8'hE0) ? (val - 8'h20) : val;
        sb_q.delete();
        cur_eff  = eff;
        done_cnt = 0;
        for (int i = 0; i < DMA_LEN; i++)
            sb_q.push_back('{mc: p + 1 + START_DELAY + i, idx: 8'(i), data: mem[{eff, 8'(i)}]});
        @(posedge clk);
        #1;
        bus.cpu_p_wr = 1'b0;
        bus.cpu_adr  = 16'h0000;
        bus.cpu_dout = 8'h00;
        check("start_not_active", bus.dma_active, 0);
    endtask

    // One combinational CPU access placed between mcyc pulses.
    task automatic probe(input logic [15:0] a, input logic [7:0] d, input logic rd,
                         input logic wr, output snap_t s);
        wait_mcyc_high();
        @(negedge clk);
        #1;
        bus.cpu_adr  = a;
        bus.cpu_dout = d;
        bus.cpu_p_rd = rd;
        bus.cpu_p_wr = wr;
        #1;
        s.cdin = bus.cpu_din;
        s.adr  = bus.adr;
        s.dout = bus.dout;
        s.p_rd = bus.p_rd;
        s.n_rd = bus.n_rd;
        s.p_wr = bus.p_wr;
        s.n_wr = bus.n_wr;
        bus.cpu_adr  = 16'h0000;
        bus.cpu_dout = 8'h00;
        bus.cpu_p_rd = 1'b0;
        bus.cpu_p_wr = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (done_cnt < n && t < 8 * DMA_LEN) begin
            @(negedge clk);
            t++;
        end
        check("wait_writes", 32'(done_cnt >= n), 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 8 * DMA_LEN) begin
            @(negedge clk);
            t++;
        end
        check("transfer_complete", sb_q.size(), 0);
        check("dma_active_idle", bus.dma_active, 0);
    endtask

    task automatic check_enters_xfer();
        wait_mcyc_high();
        @(posedge clk);
        #1;
        check("xfer_after_delay", bus.dma_active, 1);
    endtask

    initial begin
        snap_t s;
        logic [7:0] blk;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < DMA_LEN; i++) mem[16'hC000 + i] = 8'(i);

        bus.cpu_adr  = 16'h0000;
        bus.cpu_dout = 8'h00;
        bus.cpu_p_rd = 1'b0;
        bus.cpu_p_wr = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dma_active", bus.dma_active, 0);
        check("rst_oam_we", bus.oam_we, 0);
        check("rst_oam_adr", bus.oam_adr, 0);
        check("rst_oam_wdata", bus.oam_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle pass-through.
        probe(16'hFF46, 8'h00, 1'b1, 1'b0, s);
        check("rst_ff46", s.cdin, 8'h00);
        probe(16'h0150, 8'h00, 1'b1, 1'b0, s);
        check("idle_rd_adr", s.adr, 16'h0150);
        check("idle_rd_data", s.cdin, mem[16'h0150]);
        check("idle_p_rd", s.p_rd, 1);
        check("idle_n_rd", s.n_rd, 0);
        check("idle_n_wr", s.n_wr, 1);
        probe(16'hC123, 8'h55, 1'b0, 1'b1, s);
        check("idle_wr_adr", s.adr, 16'hC123);
        check("idle_wr_dout", s.dout, 8'h55);
        check("idle_p_wr", s.p_wr, 1);
        check("idle_n_wr_low", s.n_wr, 0);

        // Basic copy from C000 (value == index).
        reg_write(8'hC0);
        check_enters_xfer();
        wait_done();
        repeat (16) @(negedge clk);
        check("basic_pulse_count", done_cnt, DMA_LEN);

        // Readback and blocking during a transfer.
        reg_write(8'h8A);
        wait_writes(5);
        probe(16'hFF46, 8'h00, 1'b1, 1'b0, s);
        check("rb_during", s.cdin, 8'h8A);
        check("rb_during_adr", s.adr, 16'hFF46);
        probe(16'h0150, 8'h00, 1'b1, 1'b0, s);
`ifdef OAM_DMA_BUS_CONFLICT_EN
        blk = mem[{cur_eff, 8'(done_cnt)}];
`else
        blk = 8'hFF;
`endif
        check("blk_rd_data", s.cdin, blk);
        check("blk_rd_adr", s.adr, {8'h8A, 8'(done_cnt)});
        check("blk_rd_p_rd", s.p_rd, 1);
        probe(16'hC123, 8'h55, 1'b0, 1'b1, s);
        check("blk_wr_p_wr", s.p_wr, 0);
        check("blk_wr_n_wr", s.n_wr, 1);
        check("blk_wr_adr", s.adr, {8'h8A, 8'(done_cnt)});
        check("blk_wr_dout", s.dout, 8'h00);
        probe(16'hFF80, 8'h00, 1'b1, 1'b0, s);
        check("hi_rd_adr", s.adr, 16'hFF80);
        check("hi_rd_data", s.cdin, mem[16'hFF80]);
        check("hi_rd_p_rd", s.p_rd, 1);
        check("blk_still_active", bus.dma_active, 1);
        wait_done();
        probe(16'hFF46, 8'h00, 1'b1, 1'b0, s);
        check("rb_after", s.cdin, 8'h8A);

        // Restart after 40 bytes.
        reg_write(8'h12);
        wait_writes(40);
        check("restart_at_40", done_cnt, 40);
        reg_write(8'hD0);
        check_enters_xfer();
        wait_done();

        // Echo-region mirroring.
        reg_write(8'hE5);
        wait_writes(3);
        probe(16'h0000, 8'h00, 1'b0, 1'b0, s);
        check("mirror_adr", s.adr, {8'hC5, 8'(done_cnt)});
        check("mirror_p_rd", s.p_rd, 1);
        check("mirror_n_rd", s.n_rd, 0);
        probe(16'hFF46, 8'h00, 1'b1, 1'b0, s);
        check("mirror_rb", s.cdin, 8'hE5);
        wait_done();

        // Reset in the middle of a transfer.
        reg_write(8'h47);
        wait_writes(10);
        sb_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_dma_active", bus.dma_active, 0);
        check("midrst_oam_we", bus.oam_we, 0);
        probe(16'hFF46, 8'h00, 1'b1, 1'b0, s);
        check("midrst_ff46", s.cdin, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (16) @(negedge clk);
        check("midrst_no_more_writes", done_cnt, 10);
        check("midrst_idle", bus.dma_active, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
